// File: rtl/rename_pkg.sv
// Shared sizing and packet types for the register-rename stage.
package rename_pkg;

    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PHYS_REGS = 64;
    localparam int unsigned PR_BITS   = $clog2(PHYS_REGS);
    localparam int unsigned AR_BITS   = $clog2(ARCH_REGS);
    localparam int unsigned FC_BITS   = $clog2(PHYS_REGS + 1);

    typedef struct packed {
        logic [PR_BITS-1:0] src1;
        logic [PR_BITS-1:0] src2;
        logic [PR_BITS-1:0] dst;
        logic [PR_BITS-1:0] old_dst;
        logic               rdy1;
        logic               rdy2;
    } rename_pkt_t;

endpackage

// File: rtl/rename_unit_free_list.sv
// Bitmap free list: lowest-index allocation (p0 excluded), release, and
// bulk reload on flush.
module free_list
    import rename_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_en,
    output logic [PR_BITS-1:0]   alloc_idx,
    input  logic                 release_en,
    input  logic [PR_BITS-1:0]   release_idx,
    input  logic                 flush_load,
    input  logic [PHYS_REGS-1:0] flush_map,
    output logic [FC_BITS-1:0]   free_count
);

    logic [PHYS_REGS-1:0] bitmap;

    // Descending scan so the last hit, the lowest free index, wins.
    always_comb begin
        alloc_idx = '0;
        for (int unsigned i = PHYS_REGS - 1; i > 0; i--) begin
            if (bitmap[i]) alloc_idx = PR_BITS'(i);
        end
    end

    always_comb begin
        free_count = '0;
        for (int unsigned i = 0; i < PHYS_REGS; i++) begin
            free_count = free_count + FC_BITS'(bitmap[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap <= {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
        end else if (flush_load) begin
            bitmap <= flush_map;
        end else begin
            if (alloc_en)   bitmap[alloc_idx]   <= 1'b0;
            if (release_en) bitmap[release_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/rename_unit.sv
// Rename stage: speculative RAT, retirement RAT for flush recovery,
// per-physical ready bits and a registered dispatch packet.
module rename_unit
    import rename_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [AR_BITS-1:0] in_rs1,
    input  logic [AR_BITS-1:0] in_rs2,
    input  logic [AR_BITS-1:0] in_rd,
    input  logic               in_rd_wen,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PR_BITS-1:0] out_src1,
    output logic [PR_BITS-1:0] out_src2,
    output logic               out_src1_ready,
    output logic               out_src2_ready,
    output logic [PR_BITS-1:0] out_dst,
    output logic [PR_BITS-1:0] out_old_dst,
    input  logic               wb_valid,
    input  logic [PR_BITS-1:0] wb_phys,
    input  logic               commit_valid,
    input  logic [AR_BITS-1:0] commit_rd,
    input  logic [PR_BITS-1:0] commit_dst,
    input  logic [PR_BITS-1:0] commit_old_dst,
    input  logic               flush,
    output logic [FC_BITS-1:0] free_count
);

    logic [PR_BITS-1:0]   rat       [ARCH_REGS];
    logic [PR_BITS-1:0]   rrat      [ARCH_REGS];
    logic [PR_BITS-1:0]   rrat_next [ARCH_REGS];
    logic [PHYS_REGS-1:0] ready;
    logic [PHYS_REGS-1:0] flush_map;
    logic [PR_BITS-1:0]   src1, src2, alloc_idx;
    logic                 fire, alloc, release_en;
    rename_pkt_t          pkt, pkt_next;

    free_list u_free_list (
        .clk         (clk),
        .rst         (rst),
        .alloc_en    (fire && alloc),
        .alloc_idx   (alloc_idx),
        .release_en  (release_en),
        .release_idx (commit_old_dst),
        .flush_load  (flush),
        .flush_map   (flush_map),
        .free_count  (free_count)
    );

    assign in_ready   = !flush && (!out_valid || out_ready) && (free_count != '0);
    assign fire       = in_valid && in_ready;
    assign alloc      = in_rd_wen && (in_rd != '0);
    assign release_en = commit_valid && (commit_old_dst != '0);

    assign src1 = rat[in_rs1];
    assign src2 = rat[in_rs2];

    always_comb begin
        pkt_next.src1    = src1;
        pkt_next.src2    = src2;
        pkt_next.rdy1    = ready[src1] || (wb_valid && wb_phys == src1) || (src1 == '0);
        pkt_next.rdy2    = ready[src2] || (wb_valid && wb_phys == src2) || (src2 == '0);
        pkt_next.dst     = alloc ? alloc_idx : '0;
        pkt_next.old_dst = alloc ? rat[in_rd] : '0;
    end

    always_comb begin
        for (int unsigned i = 0; i < ARCH_REGS; i++) rrat_next[i] = rrat[i];
        if (commit_valid && commit_rd != '0) rrat_next[commit_rd] = commit_dst;
    end

    // Anything the committed map still names stays allocated after flush.
    always_comb begin
        flush_map = '1;
        for (int unsigned i = 0; i < ARCH_REGS; i++) flush_map[rrat_next[i]] = 1'b0;
        flush_map[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
                rat[i]  <= PR_BITS'(i);
                rrat[i] <= PR_BITS'(i);
            end
            ready     <= '1;
            out_valid <= 1'b0;
            pkt       <= '0;
        end else begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) rrat[i] <= rrat_next[i];
            if (flush) begin
                for (int unsigned i = 0; i < ARCH_REGS; i++) rat[i] <= rrat_next[i];
                ready     <= '1;
                out_valid <= 1'b0;
            end else begin
                if (wb_valid && wb_phys != '0) ready[wb_phys] <= 1'b1;
                if (fire && alloc) begin
                    rat[in_rd]       <= alloc_idx;
                    ready[alloc_idx] <= 1'b0;
                end
                if (fire) begin
                    out_valid <= 1'b1;
                    pkt       <= pkt_next;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end else if (out_valid && wb_valid) begin
                    if (pkt.src1 == wb_phys) pkt.rdy1 <= 1'b1;
                    if (pkt.src2 == wb_phys) pkt.rdy2 <= 1'b1;
                end
            end
        end
    end

    assign out_src1       = pkt.src1;
    assign out_src2       = pkt.src2;
    assign out_src1_ready = pkt.rdy1;
    assign out_src2_ready = pkt.rdy2;
    assign out_dst        = pkt.dst;
    assign out_old_dst    = pkt.old_dst;

endmodule

// File: tb/tb_rename_unit.sv
// Scoreboard bench for rename_unit: directed plan sequences then random
// traffic against an array/queue model of the renaming rules.
module tb_rename_unit;
    import rename_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0, in_ready, in_rd_wen = 1'b0;
    logic [AR_BITS-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic               out_valid, out_ready = 1'b0;
    logic [PR_BITS-1:0] out_src1, out_src2, out_dst, out_old_dst;
    logic               out_src1_ready, out_src2_ready;
    logic               wb_valid = 1'b0, commit_valid = 1'b0, flush = 1'b0;
    logic [PR_BITS-1:0] wb_phys = '0, commit_dst = '0, commit_old_dst = '0;
    logic [AR_BITS-1:0] commit_rd = '0;
    logic [FC_BITS-1:0] free_count;

    always #5 clk = ~clk;

    rename_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_src1(out_src1),
        .out_src2(out_src2), .out_src1_ready(out_src1_ready),
        .out_src2_ready(out_src2_ready), .out_dst(out_dst), .out_old_dst(out_old_dst),
        .wb_valid(wb_valid), .wb_phys(wb_phys), .commit_valid(commit_valid),
        .commit_rd(commit_rd), .commit_dst(commit_dst), .commit_old_dst(commit_old_dst),
        .flush(flush), .free_count(free_count)
    );

    typedef struct {
        int s1, s2, dst, old_dst, rd;
        bit r1, r2;
        int issue;
    } exp_t;

    exp_t sb[$];
    exp_t rob[$];
    int   rat_m[32], rrat_m[32], last_wb[64];
    bit   free_m[64], ready_m[64];
    bit   mval;
    int   cyc = 0, tests = 0, fails = 0;
    int   snap_s1, snap_s2, snap_d, snap_o, snap_fc;
    bit   snap_v, snap_r1, snap_r2;

    task automatic ck(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nfree();
        int n = 0;
        for (int p = 0; p < 64; p++) n += int'(free_m[p]);
        return n;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            rat_m[i]  = i;
            rrat_m[i] = i;
        end
        for (int p = 0; p < 64; p++) begin
            free_m[p]  = (p >= 32);
            ready_m[p] = 1'b1;
            last_wb[p] = 0;
        end
        mval = 1'b0;
        sb.delete();
        rob.delete();
    endfunction

    task automatic do_reset();
        @(posedge clk); cyc++; #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0;
        commit_valid = 1'b0; flush = 1'b0;
        @(posedge clk); cyc++; #1;
        rst = 1'b0;
        model_reset();
        #1;
        ck("rst_out_valid", out_valid, 0);
        ck("rst_out_dst", out_dst, 0);
        ck("rst_out_old_dst", out_old_dst, 0);
        ck("rst_free_count", free_count, 32);
        ck("rst_in_ready", in_ready, 1);
    endtask

    task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                        input bit wen, input bit ordy, input bit wbv, input int wbp,
                        input bit cmt, input bit fl);
        bit   exp_rdy, fire, do_cmt, alloc;
        int   nf;
        exp_t e, c;
        @(posedge clk); cyc++; #1;
        snap_v  = out_valid;  snap_s1 = out_src1; snap_s2 = out_src2;
        snap_d  = out_dst;    snap_o  = out_old_dst;
        snap_r1 = out_src1_ready; snap_r2 = out_src2_ready; snap_fc = free_count;
        do_cmt = cmt && rob.size() > 0;
        if (do_cmt) c = rob[0];
        in_valid = v; in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd); in_rd_wen = wen;
        out_ready = ordy && !fl;
        wb_valid = wbv; wb_phys = 6'(wbp);
        commit_valid   = do_cmt;
        commit_rd      = do_cmt ? 5'(c.rd) : '0;
        commit_dst     = do_cmt ? 6'(c.dst) : '0;
        commit_old_dst = do_cmt ? 6'(c.old_dst) : '0;
        flush = fl;
        nf = nfree();
        exp_rdy = !fl && (!mval || out_ready) && nf >= 1;
        #1;
        ck("out_valid", out_valid, mval);
        ck("in_ready", in_ready, exp_rdy);
        ck("free_count", free_count, nf);
        fire  = v && exp_rdy;
        alloc = wen && rd != 0;
        if (fire) begin
            e.s1 = rat_m[rs1];
            e.s2 = rat_m[rs2];
            e.r1 = ready_m[e.s1] || (wbv && wbp == e.s1) || e.s1 == 0;
            e.r2 = ready_m[e.s2] || (wbv && wbp == e.s2) || e.s2 == 0;
            e.rd = rd; e.dst = 0; e.old_dst = 0;
            if (alloc) begin
                for (int p = 63; p >= 1; p--) if (free_m[p]) e.dst = p;
                e.old_dst = rat_m[rd];
            end
            e.issue = cyc + 1;
            sb.push_back(e);
        end
        if (wbv && wbp != 0) begin
            ready_m[wbp] = 1'b1;
            last_wb[wbp] = cyc + 1;
        end
        if (fire && alloc) begin
            free_m[e.dst]  = 1'b0;
            ready_m[e.dst] = 1'b0;
            rat_m[rd]      = e.dst;
        end
        if (do_cmt) begin
            void'(rob.pop_front());
            rrat_m[c.rd] = c.dst;
            if (c.old_dst != 0) free_m[c.old_dst] = 1'b1;
        end
        if (fl) begin
            for (int p = 0; p < 64; p++) begin
                free_m[p]  = (p != 0);
                ready_m[p] = 1'b1;
            end
            for (int i = 0; i < 32; i++) begin
                rat_m[i] = rrat_m[i];
                free_m[rrat_m[i]] = 1'b0;
            end
            mval = 1'b0;
            sb.delete();
            rob.delete();
        end else begin
            mval = fire ? 1'b1 : (out_ready ? 1'b0 : mval);
        end
    endtask

    // Monitor: every transfer on the dispatch side pops one expected packet.
    initial begin : monitor
        exp_t e;
        bit   er1, er2;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_pkt: got dst %0d expected no packet (cycle %0d)", out_dst, cyc);
                end else begin
                    e = sb.pop_front();
                    er1 = e.r1 || (last_wb[e.s1] > e.issue && last_wb[e.s1] <= cyc);
                    er2 = e.r2 || (last_wb[e.s2] > e.issue && last_wb[e.s2] <= cyc);
                    ck("pkt_tags", {out_src1, out_src2, out_dst, out_old_dst},
                       {6'(e.s1), 6'(e.s2), 6'(e.dst), 6'(e.old_dst)});
                    ck("pkt_rdy", {out_src1_ready, out_src2_ready}, {er1, er2});
                    if (e.dst != 0) rob.push_back(e);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int  cand[$];
        bit  wbv;
        int  wbp;
        do_reset();
        // add x5,x1,x2 then back-to-back x6 <- x5,x5
        step(1, 1, 2, 5, 1, 1, 0, 0, 0, 0);
        step(1, 5, 5, 6, 1, 1, 0, 0, 0, 0);
        ck("a_src1", snap_s1, 1); ck("a_src2", snap_s2, 2);
        ck("a_dst", snap_d, 32); ck("a_old", snap_o, 5);
        ck("a_rdy", {snap_r1, snap_r2}, 2'b11); ck("a_fc", snap_fc, 31);
        step(0, 0, 0, 0, 0, 0, 1, 32, 0, 0);
        ck("b_src1", snap_s1, 32); ck("b_rdy_before", snap_r1, 0);
        ck("b_dst", snap_d, 33); ck("b_old", snap_o, 6);
        step(1, 1, 1, 9, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 9, 1, 0, 0, 0, 0, 0);
        ck("b_held_dst", snap_d, 33); ck("b_rdy_woken", {snap_r1, snap_r2}, 2'b11);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // bypass: producer written back in the consumer's rename cycle
        step(1, 1, 1, 7, 1, 1, 0, 0, 0, 0);
        step(1, 7, 0, 8, 1, 1, 1, 34, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ck("d_src1", snap_s1, 34); ck("d_bypass_rdy", snap_r1, 1);
        ck("d_src2_p0", {snap_s2, snap_r2}, 1); ck("d_dst", snap_d, 35);
        // non-allocating rename
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ck("x0_valid", snap_v, 1); ck("x0_dst", snap_d, 0);
        ck("x0_old", snap_o, 0); ck("x0_fc", snap_fc, 28);
        // retire everything, then x3 twice, commit the first, flush
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        step(1, 3, 3, 3, 1, 1, 0, 0, 0, 0);
        ck("commit_fc", snap_fc, 32);
        step(1, 3, 3, 3, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        step(1, 3, 3, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ck("flush_src1", snap_s1, 5); ck("flush_rdy", snap_r1, 1);
        ck("flush_fc", snap_fc, 32);
        // exhaust the free list, then free one by commit
        for (int k = 0; k < 34; k++) step(1, 1, 2, (k % 30) + 1, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        ck("empty_fc", snap_fc, 0);
        step(1, 2, 3, 9, 1, 1, 0, 0, 0, 0);
        ck("freed_fc", snap_fc, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // random traffic with one mid-run reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cand.delete();
            for (int p = 1; p < 64; p++) if (!ready_m[p] && !free_m[p]) cand.push_back(p);
            wbv = cand.size() > 0 && $urandom_range(0, 1) == 1;
            wbp = wbv ? cand[$urandom_range(0, cand.size() - 1)] : 0;
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 wbv, wbp, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
        end
        for (int k = 0; k < 20 && sb.size() > 0; k++) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        ck("drain_pending", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
